// File: rtl/sic_issue_dispatch.sv
// Packet FIFO feeding NUM_SICS execution units: one round-robin dispatch per cycle, issue_id tagged.
// Optional DISPATCH_BYPASS_EN: an incoming packet goes straight to a waiting SIC when the FIFO is empty.
module sic_issue_dispatch #(
   parameter int NUM_SICS   = 4,
   parameter int PKT_W      = 64,
   parameter int ID_WIDTH   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PKT_W-1:0]              in_pkt,
   input  logic                          flush,
   input  logic [NUM_SICS-1:0]           sic_req_instr,
   output logic [NUM_SICS-1:0]           sic_pkt_valid,
   output logic [PKT_W-1:0]              sic_pkt,
   output logic [ID_WIDTH-1:0]           sic_issue_id,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SEL_W = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [SEL_W-1:0] LAST_SIC   = SEL_W'(NUM_SICS - 1);

   logic [PKT_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0] id_cnt_q, id_cnt_d;
   logic [NUM_SICS-1:0] valid_q, valid_d;
   logic [PKT_W-1:0]    pkt_q, pkt_d;
   logic [ID_WIDTH-1:0] issue_id_q, issue_id_d;

   logic                fifo_empty;
   logic                fifo_full;
   logic [NUM_SICS-1:0] cand;
   logic                grant_found;
   logic [SEL_W-1:0]    grant_idx;
   logic                bypass;
   logic                pop;
   logic                push;
   logic                dispatch;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_COUNT);
   assign in_ready   = !fifo_full;

   // A SIC whose pulse is on the bus this cycle may still show its stale request.
   assign cand = sic_req_instr & ~valid_q;

   // Round-robin search: first candidate at or after rr_ptr_q, wrapping.
   always_comb begin
      int               idx;
      logic [SEL_W-1:0] sel;
      // NOTE: every comb output gets a default before any branch so no latch is inferred.
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      sel         = '0;
      for (int i = 0; i < NUM_SICS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_SICS) idx = idx - NUM_SICS;
         sel = SEL_W'(idx);
         if (!grant_found && cand[sel]) begin
            grant_found = 1'b1;
            grant_idx   = sel;
         end
      end
   end

`ifdef DISPATCH_BYPASS_EN
   assign bypass = fifo_empty && in_valid && grant_found && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign pop      = !fifo_empty && grant_found && !flush;
   assign dispatch = pop || bypass;
   assign push     = in_valid && !fifo_full && !flush && !bypass;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rr_ptr_d   = rr_ptr_q;
      id_cnt_d   = id_cnt_q;
      valid_d    = '0;
      pkt_d      = pkt_q;
      issue_id_d = issue_id_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      if (dispatch) begin
         valid_d[grant_idx] = 1'b1;
         pkt_d              = bypass ? in_pkt : mem_q[rd_ptr_q];
         issue_id_d         = id_cnt_q;
         id_cnt_d           = id_cnt_q + 1'b1;
         rr_ptr_d           = (grant_idx == LAST_SIC) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rr_ptr_q   <= '0;
         id_cnt_q   <= '0;
         valid_q    <= '0;
         pkt_q      <= '0;
         issue_id_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rr_ptr_q   <= rr_ptr_d;
         id_cnt_q   <= id_cnt_d;
         valid_q    <= valid_d;
         pkt_q      <= pkt_d;
         issue_id_q <= issue_id_d;
      end
   end

   // NOTE: packet storage has no reset; count/pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_pkt;
   end

   assign sic_pkt_valid = valid_q;
   assign sic_pkt       = pkt_q;
   assign sic_issue_id  = issue_id_q;
   assign fifo_count    = count_q;

endmodule

// File: tb/tb_sic_issue_dispatch.sv
// Randomised and directed bench for sic_issue_dispatch against a queue-based reference model.
// A second instance with ID_WIDTH=2 shares all stimulus to observe issue_id wrap-around.
module tb_sic_issue_dispatch;

   localparam int N   = 4;
   localparam int PW  = 64;
   localparam int IW  = 8;
   localparam int IW2 = 2;
   localparam int D   = 4;
   localparam int CW  = $clog2(D) + 1;
   localparam int VW  = 2 * (N + PW + CW + 1) + IW + IW2;

`ifdef DISPATCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic [PW-1:0]  in_pkt = '0;
   logic           flush = 1'b0;
   logic [N-1:0]   sic_req_instr = '0;

   logic           in_ready;
   logic [N-1:0]   sic_pkt_valid;
   logic [PW-1:0]  sic_pkt;
   logic [IW-1:0]  sic_issue_id;
   logic [CW-1:0]  fifo_count;

   logic           w2_ready;
   logic [N-1:0]   w2_valid;
   logic [PW-1:0]  w2_pkt;
   logic [IW2-1:0] w2_id;
   logic [CW-1:0]  w2_count;

   always #5 clk = ~clk;

   sic_issue_dispatch #(.NUM_SICS(N), .PKT_W(PW), .ID_WIDTH(IW), .FIFO_DEPTH(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
      .flush(flush), .sic_req_instr(sic_req_instr), .sic_pkt_valid(sic_pkt_valid),
      .sic_pkt(sic_pkt), .sic_issue_id(sic_issue_id), .fifo_count(fifo_count)
   );

   sic_issue_dispatch #(.NUM_SICS(N), .PKT_W(PW), .ID_WIDTH(IW2), .FIFO_DEPTH(D)) u_dut_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w2_ready), .in_pkt(in_pkt),
      .flush(flush), .sic_req_instr(sic_req_instr), .sic_pkt_valid(w2_valid),
      .sic_pkt(w2_pkt), .sic_issue_id(w2_id), .fifo_count(w2_count)
   );

   // Reference model state: buffered packets, bus contents, issue counter, rr position.
   logic [PW-1:0] mq[$];
   logic [N-1:0]  m_valid;
   logic [PW-1:0] m_pkt;
   int            m_id;
   int            m_cnt;
   int            m_rr;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic model_reset();
      mq.delete();
      m_valid = '0;
      m_pkt   = '0;
      m_id    = 0;
      m_cnt   = 0;
      m_rr    = 0;
   endtask

   function automatic logic [VW-1:0] act_vec();
      return {sic_pkt_valid, sic_pkt, sic_issue_id, fifo_count, in_ready,
              w2_valid, w2_pkt, w2_id, w2_count, w2_ready};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [CW-1:0] c;
      logic          r;
      c = CW'(mq.size());
      r = (mq.size() < D);
      return {m_valid, m_pkt, IW'(m_id), c, r, m_valid, m_pkt, IW2'(m_id), c, r};
   endfunction

   // Drive one cycle of inputs, advance the model by the dispatch rules, settle after the edge.
   task automatic step(input logic v, input logic [PW-1:0] p, input logic f, input logic [N-1:0] r);
      logic [N-1:0] cand;
      logic [N-1:0] oh;
      bit           acc;
      bit           byp;
      int           g;
      @(negedge clk);
      in_valid      = v;
      in_pkt        = p;
      flush         = f;
      sic_req_instr = r;
      cand = r & ~m_valid;
      acc  = v && (mq.size() < D);
      byp  = BYP && (mq.size() == 0) && v && (cand != 0) && !f;
      if (f) begin
         mq.delete();
         m_valid = '0;
      end else begin
         if ((cand != 0) && ((mq.size() > 0) || byp)) begin
            g = -1;
            for (int i = 0; i < N; i++) begin
               int k;
               k = (m_rr + i) % N;
               if (g < 0 && cand[k]) g = k;
            end
            m_pkt = byp ? p : mq.pop_front();
            oh    = '0;
            oh[g] = 1'b1;
            m_valid = oh;
            m_id  = m_cnt;
            m_cnt = m_cnt + 1;
            m_rr  = (g + 1) % N;
         end else begin
            m_valid = '0;
         end
         if (acc && !byp) mq.push_back(p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0; in_pkt = '0; flush = 1'b0; sic_req_instr = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; in_pkt = '0; flush = 1'b0; sic_req_instr = '0;
      model_reset();
      #3;
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL reset_state: got %h expected %h", act_vec(), exp_vec());
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0, '0);
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_first_packet();
      int            lat;
      int            exp_lat;
      logic [N-1:0]  got_v;
      logic [PW-1:0] got_p;
      logic [IW-1:0] got_id;
      reset_dut();
      exp_lat = BYP ? 1 : 2;
      lat = 0; got_v = '0; got_p = '0; got_id = '0;
      for (int k = 1; k <= 3; k++) begin
         step(k == 1, (k == 1) ? 64'hA1 : 64'h0, 1'b0, 4'b0001);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL first_pkt_cycle%0d: got %h expected %h", k, act_vec(), exp_vec());
         else n_pass++;
         if (lat == 0 && sic_pkt_valid != 0) begin
            lat = k; got_v = sic_pkt_valid; got_p = sic_pkt; got_id = sic_issue_id;
         end
      end
      n_checks++;
      if (lat !== exp_lat) $display("FAIL first_pkt_latency: got %0d expected %0d", lat, exp_lat);
      else n_pass++;
      n_checks++;
      if ({got_v, got_p, got_id} !== {4'b0001, 64'hA1, 8'h00})
         $display("FAIL first_pkt_payload: got v=%b pkt=%h id=%0d expected v=0001 pkt=a1 id=0", got_v, got_p, got_id);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] grants[$];
      logic [N-1:0] exp_g[4];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         step(k < 4, {32'h0, $urandom}, 1'b0, 4'b1111);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL rr_cycle%0d: got %h expected %h", k, act_vec(), exp_vec());
         else n_pass++;
         if (sic_pkt_valid != 0) grants.push_back(sic_pkt_valid);
      end
      n_checks++;
      if (grants.size() != 4) $display("FAIL rr_grant_count: got %0d expected 4", grants.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < grants.size(); i++) begin
         n_checks++;
         if (grants[i] !== exp_g[i]) $display("FAIL rr_grant%0d: got %b expected %b", i, grants[i], exp_g[i]);
         else n_pass++;
      end
   endtask

   task automatic test_fill();
      logic [PW-1:0] pk[5];
      reset_dut();
      for (int k = 0; k < 5; k++) pk[k] = {$urandom, $urandom};
      for (int k = 0; k < 5; k++) begin
         step(1'b1, pk[k], 1'b0, 4'b0000);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL fill_push%0d: got %h expected %h", k, act_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({in_ready, fifo_count} !== {1'b0, 3'd4})
         $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=4", in_ready, fifo_count);
      else n_pass++;
      step(1'b0, '0, 1'b0, 4'b0100);
      n_checks++;
      if ({sic_pkt_valid, sic_pkt, in_ready, fifo_count} !== {4'b0100, pk[0], 1'b1, 3'd3})
         $display("FAIL fill_pop: got v=%b pkt=%h ready=%b count=%0d expected v=0100 pkt=%h ready=1 count=3",
                  sic_pkt_valid, sic_pkt, in_ready, fifo_count, pk[0]);
      else n_pass++;
      step(1'b0, '0, 1'b0, 4'b0000);
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL fill_after: got %h expected %h", act_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_id_wrap();
      logic [IW2-1:0] ids[$];
      logic [IW2-1:0] exp_ids[5];
      exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      reset_dut();
      for (int k = 0; k < 10; k++) begin
         step(k < 5, {$urandom, $urandom}, 1'b0, 4'b1111);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL idwrap_cycle%0d: got %h expected %h", k, act_vec(), exp_vec());
         else n_pass++;
         if (w2_valid != 0) ids.push_back(w2_id);
      end
      n_checks++;
      if (ids.size() != 5) $display("FAIL idwrap_count: got %0d expected 5", ids.size());
      else n_pass++;
      for (int i = 0; i < 5 && i < ids.size(); i++) begin
         n_checks++;
         if (ids[i] !== exp_ids[i]) $display("FAIL idwrap_id%0d: got %0d expected %0d", i, ids[i], exp_ids[i]);
         else n_pass++;
      end
   endtask

   task automatic test_flush();
      int            next_id;
      logic [IW-1:0] got_id;
      bit            seen;
      step(1'b0, '0, 1'b0, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, {$urandom, $urandom}, 1'b0, 4'b0000);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL flush_fill%0d: got %h expected %h", k, act_vec(), exp_vec());
         else n_pass++;
      end
      next_id = m_cnt;
      step(1'b1, 64'hDEAD, 1'b1, 4'b1111);
      n_checks++;
      if ({sic_pkt_valid, fifo_count, in_ready} !== {4'b0000, 3'd0, 1'b1})
         $display("FAIL flush_empty: got v=%b count=%0d ready=%b expected v=0000 count=0 ready=1",
                  sic_pkt_valid, fifo_count, in_ready);
      else n_pass++;
      seen = 1'b0; got_id = '0;
      for (int k = 0; k < 4; k++) begin
         step(k == 0, 64'hF00D, 1'b0, 4'b1111);
         n_checks++;
         if (act_vec() !== exp_vec()) $display("FAIL flush_resume%0d: got %h expected %h", k, act_vec(), exp_vec());
         else n_pass++;
         if (!seen && sic_pkt_valid != 0) begin seen = 1'b1; got_id = sic_issue_id; end
      end
      n_checks++;
      if (!seen || got_id !== IW'(next_id))
         $display("FAIL flush_next_id: got seen=%b id=%0d expected id=%0d", seen, got_id, next_id);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 15) == 0, N'($urandom));
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            if (errs < 10) $display("FAIL random_cycle%0d: got %h expected %h", k, act_vec(), exp_vec());
            errs++;
         end else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, '0, 1'b0, 4'b0000);
      for (int k = 0; k < 6; k++) begin
         if (mq.size() < D) step(1'b1, {$urandom, $urandom}, 1'b0, 4'b0000);
      end
      step(1'b0, '0, 1'b0, 4'b0001);
      n_checks++;
      if ({sic_pkt_valid, fifo_count} !== {4'b0001, 3'd3})
         $display("FAIL areset_setup: got v=%b count=%0d expected v=0001 count=3", sic_pkt_valid, fifo_count);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0; in_pkt = '0; flush = 1'b0; sic_req_instr = '0;
      model_reset();
      #1;
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL areset_immediate: got %h expected %h", act_vec(), exp_vec());
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0, 4'b0000);
      n_checks++;
      if (act_vec() !== exp_vec()) $display("FAIL areset_after: got %h expected %h", act_vec(), exp_vec());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_packet();
      test_round_robin();
      test_fill();
      test_id_wrap();
      test_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
